// File: rtl/pmu_xbar_counter_bank.sv
// PMU event-counter core: registered event crossbar feeding per-counter level/edge
// counters with preload, sticky overflow flags and an aggregated overflow interrupt.
module pmu_xbar_counter_bank #(
  parameter int unsigned  REG_WIDTH  = 32,
  parameter int unsigned  N_COUNTERS = 24,
  parameter int unsigned  N_SOC_EV   = 32,
  localparam int unsigned SEL_W      = $clog2(N_SOC_EV),
  localparam int unsigned IDX_W      = $clog2(N_COUNTERS)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            en_i,
  input  logic                            softrst_i,
  input  logic [N_SOC_EV-1:0]             events_i,
  input  logic [N_COUNTERS*SEL_W-1:0]     sel_i,
  input  logic [N_COUNTERS-1:0]           edge_mode_i,
  input  logic                            wr_en_i,
  input  logic [IDX_W-1:0]                wr_idx_i,
  input  logic [REG_WIDTH-1:0]            wr_data_i,
  input  logic [N_COUNTERS-1:0]           ovf_clr_i,
  output logic [N_COUNTERS*REG_WIDTH-1:0] counters_o,
  output logic [N_COUNTERS-1:0]           ovf_o,
  output logic                            intr_overflow_o
);

  logic [N_SOC_EV-1:0] ev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ev_q <= '0;
    end else begin
      ev_q <= events_i;
    end
  end

  for (genvar k = 0; k < N_COUNTERS; k++) begin : g_cnt
    logic [SEL_W-1:0]     sel;
    logic                 cbo_d, cbo_q, prev_q, inc, wr_hit;
    logic                 ovf_d, ovf_q;
    logic [REG_WIDTH-1:0] cnt_d, cnt_q;

    assign sel    = sel_i[k*SEL_W +: SEL_W];
    // Selects beyond the implemented event lines route a constant zero.
    assign cbo_d  = (32'(sel) < N_SOC_EV) ? ev_q[sel] : 1'b0;
    assign inc    = edge_mode_i[k] ? (cbo_q & ~prev_q) : cbo_q;
    assign wr_hit = wr_en_i && (wr_idx_i == IDX_W'(k));

    always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (softrst_i) begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end else begin
        if (ovf_clr_i[k]) begin
          ovf_d = 1'b0;
        end
        // Preload drops the same-cycle increment; a wrap overrides a clear.
        if (wr_hit) begin
          cnt_d = wr_data_i;
        end else if (en_i && inc) begin
          cnt_d = cnt_q + REG_WIDTH'(1);
          if (&cnt_q) begin
            ovf_d = 1'b1;
          end
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cbo_q  <= 1'b0;
        prev_q <= 1'b0;
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
      end else begin
        cbo_q  <= cbo_d;
        prev_q <= cbo_q;
        cnt_q  <= cnt_d;
        ovf_q  <= ovf_d;
      end
    end

    assign counters_o[k*REG_WIDTH +: REG_WIDTH] = cnt_q;
    assign ovf_o[k]                             = ovf_q;
  end

  assign intr_overflow_o = |ovf_o;

endmodule

// File: tb/tb_pmu_xbar_counter_bank.sv
// Directed bench for pmu_xbar_counter_bank: latency, crossbar sweep, edge/level,
// overflow, preload collision, enable/soft-reset and async reset mid-count.
module tb_pmu_xbar_counter_bank;
  localparam int unsigned REG_WIDTH  = 32;
  localparam int unsigned N_COUNTERS = 24;
  localparam int unsigned N_SOC_EV   = 32;
  localparam int unsigned SEL_W      = 5;
  localparam int unsigned IDX_W      = 5;

  logic                            clk = 1'b0;
  logic                            rst;
  logic                            en;
  logic                            softrst;
  logic [N_SOC_EV-1:0]             events;
  logic [N_COUNTERS*SEL_W-1:0]     sel;
  logic [N_COUNTERS-1:0]           edge_mode;
  logic                            wr_en;
  logic [IDX_W-1:0]                wr_idx;
  logic [REG_WIDTH-1:0]            wr_data;
  logic [N_COUNTERS-1:0]           ovf_clr;
  logic [N_COUNTERS*REG_WIDTH-1:0] counters;
  logic [N_COUNTERS-1:0]           ovf;
  logic                            intr;

  int n_checks = 0;
  int n_errors = 0;

  pmu_xbar_counter_bank dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .en_i            (en),
    .softrst_i       (softrst),
    .events_i        (events),
    .sel_i           (sel),
    .edge_mode_i     (edge_mode),
    .wr_en_i         (wr_en),
    .wr_idx_i        (wr_idx),
    .wr_data_i       (wr_data),
    .ovf_clr_i       (ovf_clr),
    .counters_o      (counters),
    .ovf_o           (ovf),
    .intr_overflow_o (intr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] cnt(input int k);
    return counters[k*REG_WIDTH +: REG_WIDTH];
  endfunction

  // 1 if any counter other than skip is non-zero (skip = -1 checks all).
  function automatic logic others_nz(input int skip);
    logic r = 1'b0;
    for (int k = 0; k < N_COUNTERS; k++) begin
      if (k != skip && cnt(k) != 32'd0) r = 1'b1;
    end
    return r;
  endfunction

  task automatic set_sel(input int k, input int v);
    sel[k*SEL_W +: SEL_W] = SEL_W'(v);
  endtask

  task automatic sel_all(input int v);
    for (int k = 0; k < N_COUNTERS; k++) set_sel(k, v);
  endtask

  task automatic drain_clear();
    events = '0;
    step(3);
    softrst = 1'b1;
    step();
    softrst = 1'b0;
  endtask

  task automatic preload(input int k, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_idx  = IDX_W'(k);
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; softrst = 1'b0; events = '0; sel = '0; edge_mode = '0;
    wr_en = 1'b0; wr_idx = '0; wr_data = '0; ovf_clr = '0;
    step(2);
    check("rst_counters", 64'(others_nz(-1)), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_intr", 64'(intr), 64'd0);
    rst = 1'b0;

    // Latency: single-cycle event 5 into counter0, level mode
    sel_all(31);
    set_sel(0, 5);
    en = 1'b1;
    events = 32'd1 << 5;
    step();
    events = '0;
    check("lat_T", 64'(cnt(0)), 64'd0);
    step();
    check("lat_T1", 64'(cnt(0)), 64'd0);
    step();
    check("lat_T2", 64'(cnt(0)), 64'd1);
    step();
    check("lat_T3", 64'(cnt(0)), 64'd1);
    drain_clear();

    // Crossbar sweep
    for (int in = 0; in < int'(N_SOC_EV); in++) begin
      for (int out = 0; out < int'(N_COUNTERS); out++) begin
        sel_all((in + 1) % 32);
        set_sel(out, in);
        events = 32'd1 << in;
        step(3);
        events = '0;
        step(3);
        check("xbar_hit", 64'(cnt(out)), 64'd3);
        check("xbar_miss", 64'(others_nz(out)), 64'd0);
        softrst = 1'b1;
        step();
        softrst = 1'b0;
      end
    end

    // Edge vs level
    sel_all(31);
    set_sel(0, 3);
    set_sel(1, 3);
    edge_mode = 24'h2;
    events = 32'd1 << 3;
    step(10);
    events = '0;
    step(3);
    check("level_cnt", 64'(cnt(0)), 64'd10);
    check("edge_cnt", 64'(cnt(1)), 64'd1);
    drain_clear();
    edge_mode = '0;
    events = 32'd1 << 3;
    step(5);
    edge_mode = 24'h2;
    step(5);
    events = '0;
    step(3);
    check("switch_level", 64'(cnt(0)), 64'd10);
    check("switch_edge", 64'(cnt(1)), 64'd3);
    edge_mode = '0;
    drain_clear();

    // Overflow
    sel_all(31);
    set_sel(2, 7);
    preload(2, 32'hFFFF_FFFE);
    check("pre_val", 64'(cnt(2)), 64'hFFFF_FFFE);
    check("pre_ovf", 64'(ovf), 64'd0);
    events = 32'd1 << 7;
    step(2);
    events = '0;
    step();
    check("ovf_allones", 64'(cnt(2)), 64'hFFFF_FFFF);
    step();
    check("ovf_wrap", 64'(cnt(2)), 64'd0);
    check("ovf_flag", 64'(ovf), 64'h4);
    check("ovf_intr", 64'(intr), 64'd1);
    preload(2, 32'hFFFF_FFFF);
    check("pre_keeps_flag", 64'(ovf), 64'h4);
    events = 32'd1 << 7;
    step();
    events = '0;
    step();
    ovf_clr = 24'h4;
    step();
    ovf_clr = '0;
    check("clr_wrap_cnt", 64'(cnt(2)), 64'd0);
    check("clr_wrap_flag", 64'(ovf), 64'h4);
    ovf_clr = 24'h4;
    step();
    ovf_clr = '0;
    check("clr_flag", 64'(ovf), 64'd0);
    check("clr_intr", 64'(intr), 64'd0);
    drain_clear();

    // Write vs increment
    set_sel(4, 9);
    events = 32'd1 << 9;
    step(5);
    check("wr_pre", 64'(cnt(4)), 64'd3);
    wr_en = 1'b1; wr_idx = 5'd4; wr_data = 32'd100;
    step();
    wr_en = 1'b0;
    check("wr_collide", 64'(cnt(4)), 64'd100);
    step();
    check("wr_next", 64'(cnt(4)), 64'd101);
    wr_en = 1'b1; wr_idx = 5'd30; wr_data = 32'd555;
    step();
    wr_en = 1'b0;
    check("wr_oob_cnt4", 64'(cnt(4)), 64'd102);
    check("wr_oob_others", 64'(others_nz(4)), 64'd0);
    drain_clear();

    // en_i / softrst_i
    set_sel(2, 9);
    preload(2, 32'hFFFF_FFFF);
    events = 32'd1 << 9;
    step(4);
    check("en_cnt4", 64'(cnt(4)), 64'd2);
    check("en_cnt2", 64'(cnt(2)), 64'd1);
    check("en_ovf", 64'(ovf), 64'h4);
    en = 1'b0;
    step(5);
    check("frozen_cnt4", 64'(cnt(4)), 64'd2);
    check("frozen_cnt2", 64'(cnt(2)), 64'd1);
    en = 1'b1;
    step();
    check("reen_cnt4", 64'(cnt(4)), 64'd3);
    softrst = 1'b1;
    step();
    softrst = 1'b0;
    check("soft_cnt", 64'(others_nz(-1)), 64'd0);
    check("soft_ovf", 64'(ovf), 64'd0);
    check("soft_intr", 64'(intr), 64'd0);
    step();
    check("soft_resume4", 64'(cnt(4)), 64'd1);
    check("soft_resume2", 64'(cnt(2)), 64'd1);

    // Async reset mid-cycle while counting
    #3;
    rst = 1'b1;
    #1;
    check("arst_immediate", 64'(others_nz(-1)), 64'd0);
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    check("arst_held", 64'(others_nz(-1)), 64'd0);
    step();
    check("refill_R1", 64'(cnt(4)), 64'd0);
    step();
    check("refill_R2", 64'(cnt(4)), 64'd0);
    step();
    check("refill_R3", 64'(cnt(4)), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
